// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, pixel type and fill-engine state encoding.
// The VGA output stage imports the same constants so read and write address maps agree.
package vga_pkg;

    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 300;
    localparam int ADDR_W    = 17;

    localparam logic [9:0] FB_W10 = 10'(FB_WIDTH);
    localparam logic [9:0] FB_H10 = 10'(FB_HEIGHT);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(FB_WIDTH);

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        CLIP,
        FILL,
        DONE
    } fill_state_t;

    // y*400 as (y<<8)+(y<<7)+(y<<4), so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] rowBase(input logic [8:0] y);
        logic [ADDR_W-1:0] w_y;
        w_y = ADDR_W'(y);
        return (w_y << 8) + (w_y << 7) + (w_y << 4);
    endfunction

endpackage

// File: rtl/raster_walker.sv
// Walks a clipped rectangle in raster order, tracking the current pixel and its row base
// address, and flags the final pixel so the fill FSM knows when to stop.
module raster_walker
    import vga_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [8:0]        x,
    input  logic [8:0]        y,
    input  logic [9:0]        x_end,
    input  logic [9:0]        y_end,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [9:0]        r_curX;
    logic [9:0]        r_curY;
    logic [ADDR_W-1:0] r_rowBase;
    logic              w_rowEnd;

    assign w_rowEnd = (r_curX == x_end - 10'd1);
    assign last     = w_rowEnd && (r_curY == y_end - 10'd1);
    assign addr     = r_rowBase + ADDR_W'(r_curX);

    // At the end of a row, return to the left edge and move the base down one stride
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_curX    <= '0;
            r_curY    <= '0;
            r_rowBase <= '0;
        end else if (start) begin
            r_curX    <= {1'b0, x};
            r_curY    <= {1'b0, y};
            r_rowBase <= rowBase(y);
        end else if (step) begin
            if (w_rowEnd) begin
                r_curX    <= {1'b0, x};
                r_curY    <= r_curY + 10'd1;
                r_rowBase <= r_rowBase + ROW_STRIDE;
            end else begin
                r_curX <= r_curX + 10'd1;
            end
        end
    end

endmodule

// File: rtl/fb_rect_filler.sv
// Rectangle fill engine: latches a command, clips it to the framebuffer and writes one
// RGB565 pixel per clock into the video RAM write port.
module fb_rect_filler
    import vga_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [8:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [15:0]       cmd_color,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data
);

    fill_state_t       r_state;
    fill_state_t       w_nextState;

    logic [8:0]        r_x;
    logic [8:0]        r_y;
    logic [8:0]        r_w;
    logic [8:0]        r_h;
    rgb565_t           r_color;

    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_wrEn;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [15:0]       r_wrData;

    logic              w_accept;
    logic [9:0]        w_xSum;
    logic [9:0]        w_ySum;
    logic [9:0]        w_xEnd;
    logic [9:0]        w_yEnd;
    logic              w_empty;
    logic              w_start;
    logic              w_step;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    assign w_accept = cmd_valid && r_ready;

    assign w_xSum  = {1'b0, r_x} + {1'b0, r_w};
    assign w_ySum  = {1'b0, r_y} + {1'b0, r_h};
    assign w_xEnd  = (w_xSum > FB_W10) ? FB_W10 : w_xSum;
    assign w_yEnd  = (w_ySum > FB_H10) ? FB_H10 : w_ySum;
    assign w_empty = (r_w == 9'd0) || (r_h == 9'd0) ||
                     ({1'b0, r_x} >= FB_W10) || ({1'b0, r_y} >= FB_H10);

    raster_walker u_walker (
        .clock (clock),
        .reset (reset),
        .start (w_start),
        .step  (w_step),
        .x     (r_x),
        .y     (r_y),
        .x_end (w_xEnd),
        .y_end (w_yEnd),
        .addr  (w_addr),
        .last  (w_last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = CLIP;
                end
            end
            CLIP: begin
                if (w_empty) begin
                    w_nextState = DONE;
                end else begin
                    w_start     = 1'b1;
                    w_nextState = FILL;
                end
            end
            FILL: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
        end else if (w_accept) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= rgb565_t'(cmd_color);
        end
    end

    // Ready stays low during the done cycle so the next accept lands strictly after done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
        end else begin
            r_ready <= (w_nextState == IDLE) && (r_state != DONE);
            r_busy  <= (w_nextState != IDLE) || (r_state == DONE);
            r_done  <= (r_state == DONE);
            r_wrEn  <= (r_state == FILL);
            if (r_state == FILL) begin
                r_wrAddr <= w_addr;
                r_wrData <= r_color;
            end
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_en     = r_wrEn;
    assign wr_addr   = r_wrAddr;
    assign wr_data   = r_wrData;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Randomised scoreboard bench for fb_rect_filler: a rectangle model predicts every write
// and done pulse with its exact cycle, and a negedge monitor pops and compares them.
module tb_fb_rect_filler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [8:0]  cmd_w = '0;
    logic [8:0]  cmd_h = '0;
    logic [15:0] cmd_color = '0;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;

    int compared = 0;
    int mismatched = 0;
    int cycleCount = 0;

    typedef struct {
        bit          isDone;
        int          addr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t expQ[$];

    fb_rect_filler dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cycleCount);
        end
    endtask

    // Rectangle model: clip with plain min(), then enumerate pixels row by row
    function automatic void pushExpected(input int x, input int y, input int w, input int h,
                                         input logic [15:0] c, input int acc);
        int  xe = (x + w > 400) ? 400 : x + w;
        int  ye = (y + h > 300) ? 300 : y + h;
        int  n  = 0;
        ev_t e;
        if (w != 0 && h != 0 && x < 400 && y < 300) begin
            for (int yy = y; yy < ye; yy++) begin
                for (int xx = x; xx < xe; xx++) begin
                    e.isDone = 1'b0;
                    e.addr   = yy * 400 + xx;
                    e.data   = c;
                    e.cyc    = acc + 2 + n;
                    expQ.push_back(e);
                    n++;
                end
            end
        end
        e.isDone = 1'b1;
        e.addr   = 0;
        e.data   = '0;
        e.cyc    = acc + 2 + n;
        expQ.push_back(e);
    endfunction

    task automatic popCompare(input bit isDone);
        ev_t e;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedEvent actual=%s expected=no event (cycle %0d)",
                     isDone ? "done" : "write", cycleCount);
        end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", longint'(isDone), longint'(e.isDone));
            checkOutput("eventCycle", cycleCount, e.cyc);
            if (!isDone && !e.isDone) begin
                checkOutput("wrAddr", longint'(wr_addr), e.addr);
                checkOutput("wrData", longint'(wr_data), longint'(e.data));
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (wr_en) popCompare(1'b0);
            if (done)  popCompare(1'b1);
        end
    end

    task automatic waitReady(input int limit);
        int n = 0;
        @(negedge clock);
        while (!cmd_ready && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL readyTimeout actual=0 expected=1 after %0d cycles", limit);
        end
        checkOutput("idleBusy", longint'(busy), 0);
    endtask

    task automatic applyStimulus(input int x, input int y, input int w, input int h, input int c);
        waitReady(20000);
        cmd_x     = 9'(x);
        cmd_y     = 9'(y);
        cmd_w     = 9'(w);
        cmd_h     = 9'(h);
        cmd_color = 16'(c);
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        pushExpected(x, y, w, h, 16'(c), cycleCount);
        checkOutput("busyAfterAccept", longint'(busy), 1);
        checkOutput("readyAfterAccept", longint'(cmd_ready), 0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstReady", longint'(cmd_ready), 0);
        checkOutput("rstBusy", longint'(busy), 0);
        checkOutput("rstDone", longint'(done), 0);
        checkOutput("rstWrEn", longint'(wr_en), 0);
        checkOutput("rstWrAddr", longint'(wr_addr), 0);
        checkOutput("rstWrData", longint'(wr_data), 0);
    endtask

    initial begin
        int x, y, w, h;

        // Power-on reset, release, then a second reset pulse while idle
        #1;
        checkResetOutputs();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("readyAfterRelease", longint'(cmd_ready), 1);
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("readyAfterIdleReset", longint'(cmd_ready), 1);

        applyStimulus(10, 2, 3, 2, 'hF800);
        applyStimulus(398, 299, 5, 4, 'h07E0);
        applyStimulus(5, 5, 0, 3, 'h1234);
        applyStimulus(400, 5, 3, 3, 'h4321);
        applyStimulus(7, 300, 3, 3, 'h5555);
        applyStimulus(0, 0, 1, 1, 'hABCD);

        // Full-width band; command pulses during the fill must be ignored
        applyStimulus(0, 0, 400, 20, 'h0000);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_x     = 9'($urandom_range(0, 399));
            cmd_y     = 9'($urandom_range(0, 299));
            cmd_w     = 9'($urandom_range(1, 9));
            cmd_h     = 9'($urandom_range(1, 9));
            cmd_color = 16'($urandom);
        end
        @(negedge clock);
        cmd_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(0, 420);
            y = $urandom_range(0, 320);
            w = $urandom_range(0, 12);
            h = $urandom_range(0, 5);
            if ($urandom_range(0, 9) == 0) begin
                w = $urandom_range(0, 511);
                h = $urandom_range(1, 2);
            end
            applyStimulus(x, y, w, h, int'($urandom_range(0, 65535)));
        end

        // Clear-screen interrupted by reset after 50 writes
        applyStimulus(0, 0, 400, 300, 'h0000);
        repeat (51) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        expQ.delete();
        checkResetOutputs();
        repeat (3) begin
            @(negedge clock);
            checkOutput("noDoneInReset", longint'(done), 0);
            checkOutput("noWriteInReset", longint'(wr_en), 0);
        end
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("readyAfterFillReset", longint'(cmd_ready), 1);
        applyStimulus(0, 0, 1, 1, 'h7E0F);

        waitReady(20000);
        checkOutput("queueEmpty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
